// File: rtl/risc_pkg.sv
// Shared definitions for the RISC datapath: ALU opcodes and control-word field positions.
// The ALU multiplier is optional and is enabled with the RISC_ALU_MUL_EN macro.
package risc_pkg;

    localparam int unsigned CTRL_W      = 12;
    localparam int unsigned CTRL_OP_LSB = 0;
    localparam int unsigned CTRL_BSEL   = 4;
    localparam int unsigned CTRL_EN     = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOR   = 4'h5,
        ALU_SLT   = 4'h6,
        ALU_SLTU  = 4'h7,
        ALU_SLL   = 4'h8,
        ALU_SRL   = 4'h9,
        ALU_SRA   = 4'hA,
        ALU_LUI   = 4'hB,
        ALU_MUL   = 4'hC,
        ALU_MULH  = 4'hD,
        ALU_PASSA = 4'hE,
        ALU_PASSB = 4'hF
    } alu_op_e;

endpackage

// File: rtl/risc_shifter.sv
// Combinational barrel shifter for the ALU's SLL/SRL/SRA ops; other ops give 0.
module risc_shifter
    import risc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [4:0]       shamt_i,
    input  alu_op_e          op_i,
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        res_o = '0;
        unique case (op_i)
            ALU_SLL: res_o = a_i << shamt_i;
            ALU_SRL: res_o = a_i >> shamt_i;
            ALU_SRA: res_o = $unsigned($signed(a_i) >>> shamt_i);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/risc_alu.sv
// Execute-stage ALU: operand mux, op decode and a registered write-back result (wtd).
// Define RISC_ALU_MUL_EN to build the MUL/MULH multiplier; otherwise those ops return 0.
module risc_alu
    import risc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    output logic [WIDTH-1:0]  wtd,
    input  logic [WIDTH-1:0]  rsd,
    input  logic [WIDTH-1:0]  rtd,
    input  logic [WIDTH-1:0]  imm,
    input  logic              clk,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              rst
);

    alu_op_e          op;
    logic             bsel;
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] wtd_d;
    logic [WIDTH-1:0] wtd_q;
    logic             unused_ctrl;

    assign op    = alu_op_e'(ctrl[CTRL_OP_LSB +: 4]);
    assign bsel  = ctrl[CTRL_BSEL];
    assign en    = ctrl[CTRL_EN];
    assign a     = rsd;
    assign b     = bsel ? imm : rtd;
    assign shamt = bsel ? imm[10:6] : rtd[4:0];

    // ctrl[11:6] are consumed by other pipeline stages
    assign unused_ctrl = ^ctrl[CTRL_W-1:CTRL_EN+1];

`ifdef RISC_ALU_MUL_EN
    logic signed [2*WIDTH-1:0] prod;
    assign prod = $signed(a) * $signed(b);
`endif

    risc_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a_i     (a),
        .shamt_i (shamt),
        .op_i    (op),
        .res_o   (shift_res)
    );

    always_comb begin
        alu_res = '0;
        unique case (op)
            ALU_ADD:   alu_res = a + b;
            ALU_SUB:   alu_res = a - b;
            ALU_AND:   alu_res = a & b;
            ALU_OR:    alu_res = a | b;
            ALU_XOR:   alu_res = a ^ b;
            ALU_NOR:   alu_res = ~(a | b);
            ALU_SLT:   alu_res[0] = ($signed(a) < $signed(b));
            ALU_SLTU:  alu_res[0] = (a < b);
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   alu_res = shift_res;
            ALU_LUI:   alu_res = b << 16;
`ifdef RISC_ALU_MUL_EN
            ALU_MUL:   alu_res = prod[WIDTH-1:0];
            ALU_MULH:  alu_res = prod[2*WIDTH-1:WIDTH];
`else
            ALU_MUL,
            ALU_MULH:  alu_res = '0;
`endif
            ALU_PASSA: alu_res = a;
            ALU_PASSB: alu_res = b;
            default:   alu_res = '0;
        endcase
    end

    assign wtd_d = en ? alu_res : wtd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wtd_q <= '0;
        end else begin
            wtd_q <= wtd_d;
        end
    end

    assign wtd = wtd_q;

endmodule

// File: tb/tb_risc_alu.sv
// Directed self-checking bench for risc_alu; MUL expectations follow RISC_ALU_MUL_EN.
module tb_risc_alu;
    import risc_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic [WIDTH-1:0]  wtd;
    logic [WIDTH-1:0]  rsd;
    logic [WIDTH-1:0]  rtd;
    logic [WIDTH-1:0]  imm;
    logic              clk;
    logic [CTRL_W-1:0] ctrl;
    logic              rst;

    int unsigned checks;
    int unsigned errors;

    risc_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .wtd  (wtd),
        .rsd  (rsd),
        .rtd  (rtd),
        .imm  (imm),
        .clk  (clk),
        .ctrl (ctrl),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] mk(input logic [3:0] op, input logic bsel, input logic en);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[3:0] = op;
        c[CTRL_BSEL] = bsel;
        c[CTRL_EN] = en;
        return c;
    endfunction

    // Apply one set of inputs across a rising edge, then settle for sampling.
    task automatic drive(input logic [3:0] op, input logic bsel, input logic en,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] i);
        ctrl = mk(op, bsel, en);
        rsd  = a;
        rtd  = b;
        imm  = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(ALU_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0);
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL reset_clear got %h expected %h", wtd, 32'd0);
        end
        rst = 1'b0;
        drive(ALU_ADD, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0);
        checks++;
        if (wtd !== 32'd12) begin
            errors++;
            $display("FAIL reset_release_add got %h expected %h", wtd, 32'd12);
        end
    endtask

    task automatic test_arith;
        drive(ALU_ADD, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0);
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL add_wrap got %h expected %h", wtd, 32'd0);
        end
        drive(ALU_SUB, 1'b0, 1'b1, 32'd3, 32'd5, 32'd0);
        checks++;
        if (wtd !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL sub_neg got %h expected %h", wtd, 32'hFFFFFFFE);
        end
    endtask

    task automatic test_logic;
        drive(ALU_AND, 1'b0, 1'b1, 32'hF0F000FF, 32'h0FF00F0F, 32'd0);
        checks++;
        if (wtd !== 32'h00F0000F) begin
            errors++;
            $display("FAIL and got %h expected %h", wtd, 32'h00F0000F);
        end
        drive(ALU_OR, 1'b0, 1'b1, 32'hF0F000FF, 32'h0FF00F0F, 32'd0);
        checks++;
        if (wtd !== 32'hFFF00FFF) begin
            errors++;
            $display("FAIL or got %h expected %h", wtd, 32'hFFF00FFF);
        end
        drive(ALU_XOR, 1'b0, 1'b1, 32'hF0F000FF, 32'h0FF00F0F, 32'd0);
        checks++;
        if (wtd !== 32'hFF000FF0) begin
            errors++;
            $display("FAIL xor got %h expected %h", wtd, 32'hFF000FF0);
        end
        drive(ALU_NOR, 1'b0, 1'b1, 32'hF0F000FF, 32'h0FF00F0F, 32'd0);
        checks++;
        if (wtd !== 32'h000FF000) begin
            errors++;
            $display("FAIL nor got %h expected %h", wtd, 32'h000FF000);
        end
    endtask

    task automatic test_imm;
        drive(ALU_ADD, 1'b1, 1'b1, 32'd16, 32'd99, 32'hFFFFFFF0);
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL add_imm got %h expected %h", wtd, 32'd0);
        end
        drive(ALU_LUI, 1'b1, 1'b1, 32'd0, 32'd0, 32'h00001234);
        checks++;
        if (wtd !== 32'h12340000) begin
            errors++;
            $display("FAIL lui got %h expected %h", wtd, 32'h12340000);
        end
        drive(ALU_PASSB, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333);
        checks++;
        if (wtd !== 32'h33333333) begin
            errors++;
            $display("FAIL passb_imm got %h expected %h", wtd, 32'h33333333);
        end
        drive(ALU_PASSB, 1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333);
        checks++;
        if (wtd !== 32'h22222222) begin
            errors++;
            $display("FAIL passb_rt got %h expected %h", wtd, 32'h22222222);
        end
        drive(ALU_PASSA, 1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333);
        checks++;
        if (wtd !== 32'h11111111) begin
            errors++;
            $display("FAIL passa got %h expected %h", wtd, 32'h11111111);
        end
    endtask

    task automatic test_shift;
        drive(ALU_SRA, 1'b0, 1'b1, 32'h80000000, 32'd31, 32'd0);
        checks++;
        if (wtd !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sra31 got %h expected %h", wtd, 32'hFFFFFFFF);
        end
        drive(ALU_SRL, 1'b0, 1'b1, 32'h80000000, 32'd31, 32'd0);
        checks++;
        if (wtd !== 32'd1) begin
            errors++;
            $display("FAIL srl31 got %h expected %h", wtd, 32'd1);
        end
        // imm[10:6]=4 -> imm = 4<<6
        drive(ALU_SLL, 1'b1, 1'b1, 32'd1, 32'd0, 32'h00000100);
        checks++;
        if (wtd !== 32'd16) begin
            errors++;
            $display("FAIL sll_imm got %h expected %h", wtd, 32'd16);
        end
        drive(ALU_SRA, 1'b0, 1'b1, 32'h80000001, 32'd0, 32'd0);
        checks++;
        if (wtd !== 32'h80000001) begin
            errors++;
            $display("FAIL sra0 got %h expected %h", wtd, 32'h80000001);
        end
        drive(ALU_SLL, 1'b0, 1'b1, 32'd3, 32'h00000020, 32'd0);
        checks++;
        if (wtd !== 32'd3) begin
            errors++;
            $display("FAIL sll_rt_bit5 got %h expected %h", wtd, 32'd3);
        end
        drive(ALU_SRA, 1'b0, 1'b1, 32'h40000000, 32'd4, 32'd0);
        checks++;
        if (wtd !== 32'h04000000) begin
            errors++;
            $display("FAIL sra_pos got %h expected %h", wtd, 32'h04000000);
        end
    endtask

    task automatic test_compare;
        drive(ALU_SLT, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0);
        checks++;
        if (wtd !== 32'd1) begin
            errors++;
            $display("FAIL slt got %h expected %h", wtd, 32'd1);
        end
        drive(ALU_SLTU, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0);
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL sltu got %h expected %h", wtd, 32'd0);
        end
        drive(ALU_SLT, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0);
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL slt_rev got %h expected %h", wtd, 32'd0);
        end
        drive(ALU_SLTU, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0);
        checks++;
        if (wtd !== 32'd1) begin
            errors++;
            $display("FAIL sltu_rev got %h expected %h", wtd, 32'd1);
        end
    endtask

    task automatic test_enable;
        drive(ALU_PASSA, 1'b0, 1'b1, 32'hCAFEF00D, 32'd0, 32'd0);
        drive(ALU_SUB, 1'b0, 1'b0, 32'd9, 32'd4, 32'd0);
        checks++;
        if (wtd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL en0_hold got %h expected %h", wtd, 32'hCAFEF00D);
        end
        drive(ALU_OR, 1'b1, 1'b0, 32'h1, 32'h2, 32'h4);
        checks++;
        if (wtd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL en0_hold2 got %h expected %h", wtd, 32'hCAFEF00D);
        end
        rst = 1'b1;
        drive(ALU_PASSA, 1'b0, 1'b0, 32'h12345678, 32'd0, 32'd0);
        rst = 1'b0;
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL rst_over_en0 got %h expected %h", wtd, 32'd0);
        end
        drive(ALU_PASSA, 1'b0, 1'b1, 32'h12345678, 32'd0, 32'd0);
        rst = 1'b1;
        drive(ALU_SUB, 1'b0, 1'b1, 32'd9, 32'd4, 32'd0);
        rst = 1'b0;
        checks++;
        if (wtd !== 32'd0) begin
            errors++;
            $display("FAIL rst_over_op got %h expected %h", wtd, 32'd0);
        end
    endtask

    task automatic test_mul;
        logic [WIDTH-1:0] exp_mul;
        logic [WIDTH-1:0] exp_mulh;
        logic [WIDTH-1:0] exp_mulh_neg;
`ifdef RISC_ALU_MUL_EN
        exp_mul      = 32'd0;
        exp_mulh     = 32'd1;
        exp_mulh_neg = 32'hFFFFFFFF;
`else
        exp_mul      = 32'd0;
        exp_mulh     = 32'd0;
        exp_mulh_neg = 32'd0;
`endif
        drive(ALU_MUL, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'd0);
        checks++;
        if (wtd !== exp_mul) begin
            errors++;
            $display("FAIL mul got %h expected %h", wtd, exp_mul);
        end
        drive(ALU_MULH, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'd0);
        checks++;
        if (wtd !== exp_mulh) begin
            errors++;
            $display("FAIL mulh got %h expected %h", wtd, exp_mulh);
        end
        // -1 * 1 = -1: high word is all ones when signed
        drive(ALU_MULH, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0);
        checks++;
        if (wtd !== exp_mulh_neg) begin
            errors++;
            $display("FAIL mulh_signed got %h expected %h", wtd, exp_mulh_neg);
        end
    endtask

    task automatic test_back_to_back;
        drive(ALU_ADD, 1'b0, 1'b1, 32'd100, 32'd23, 32'd0);
        checks++;
        if (wtd !== 32'd123) begin
            errors++;
            $display("FAIL b2b_add got %h expected %h", wtd, 32'd123);
        end
        drive(ALU_SUB, 1'b1, 1'b1, 32'd100, 32'd23, 32'd1);
        checks++;
        if (wtd !== 32'd99) begin
            errors++;
            $display("FAIL b2b_sub_imm got %h expected %h", wtd, 32'd99);
        end
        drive(ALU_XOR, 1'b0, 1'b1, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'd0);
        checks++;
        if (wtd !== 32'h55555555) begin
            errors++;
            $display("FAIL b2b_xor got %h expected %h", wtd, 32'h55555555);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b0;
        ctrl = '0;
        rsd  = '0;
        rtd  = '0;
        imm  = '0;
        test_reset();
        test_arith();
        test_logic();
        test_imm();
        test_shift();
        test_compare();
        test_enable();
        test_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
